// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT_GNT} fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, redirect input and decode-side handshake.
interface riscv_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
    );
endinterface

// File: rtl/riscv_fetch_fifo.sv
// Instruction buffer: pointer FIFO of {pc, inst} with flush; head read straight from storage flops.
module riscv_fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          valid_o,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]            rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + AW'(1);
            end
            if (pop) rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/riscv_fetch.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests and buffers
// responses for decode; a redirect flushes the buffer and discards stale responses.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic           clk,
    input logic           rst_n,
    riscv_fetch_if.master bus
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic          req_q, req_d, stale_q, stale_d;
    logic [31:0]   addr_q, addr_d, fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;

    logic          gnt, rvalid, redirect, push, pop, credit, fifo_valid;
    logic [31:0]   pc_cur;
    logic [CW-1:0] fifo_count, cnt_nxt;
    fetch_entry_t  fifo_head;

    always_comb begin
        gnt      = req_q && bus.imem_gnt_i;
        rvalid   = bus.imem_rvalid_i;
        redirect = bus.redirect_i;
        pop      = fifo_valid && bus.inst_ready_i;
        push     = rvalid && (drop_q == '0) && !redirect;
        pc_cur   = redirect ? word_align(bus.redirect_pc_i) : fetch_pc_q;
        outst_d  = outst_q + OW'(gnt) - OW'(rvalid);
        cnt_nxt  = redirect ? '0 : fifo_count + CW'(push) - CW'(pop);
        // The request being decided now may be granted next cycle, so it must
        // already fit alongside everything in flight and buffered after this edge.
        credit   = (int'(outst_d) < MAX_OUTSTANDING) &&
                   (int'(outst_d) + int'(cnt_nxt) < FIFO_DEPTH);

        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = pc_cur;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN, S_WAIT_GNT: begin
                if (req_q && !bus.imem_gnt_i) begin
                    state_d = S_WAIT_GNT;
                end else begin
                    state_d = S_RUN;
                    req_d   = credit;
                    if (credit) begin
                        addr_d     = pc_cur;
                        fetch_pc_d = pc_cur + 32'd4;
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase

        // A request still waiting for gnt at redirect time becomes stale once granted.
        if (redirect) begin
            drop_d  = outst_d;
            stale_d = req_q && !bus.imem_gnt_i;
        end else begin
            drop_d  = drop_q - OW'(rvalid && (drop_q != '0)) + OW'(gnt && stale_q);
            stale_d = stale_q && !gnt;
        end

        resp_pc_d = redirect ? word_align(bus.redirect_pc_i) :
                    push     ? resp_pc_q + 32'd4 : resp_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            req_q      <= 1'b0;
            stale_q    <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            stale_q    <= stale_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    riscv_fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ('{pc: resp_pc_q, inst: bus.imem_rdata_i}),
        .pop       (pop),
        .flush     (redirect),
        .valid_o   (fifo_valid),
        .head_o    (fifo_head),
        .count_o   (fifo_count)
    );

    assign bus.imem_req_o   = req_q;
    assign bus.imem_addr_o  = addr_q;
    assign bus.inst_valid_o = fifo_valid;
    assign bus.inst_o       = fifo_head.inst;
    assign bus.inst_pc_o    = fifo_head.pc;

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (req_q && !bus.imem_gnt_i) |=> (req_q && (addr_q == $past(addr_q))));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (int'(fifo_count) < FIFO_DEPTH));
    a_counts: assert property (@(posedge clk) disable iff (!rst_n)
        (drop_q <= outst_q) && (int'(outst_q) <= MAX_OUTSTANDING));
endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: 1-cycle in-order memory returning data=addr, decode sink.
module tb_riscv_fetch;
    import riscv_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic gnt_en, hold_resp;
    logic [31:0] mq[$], glog[$], ppc[$], pinst[$];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    riscv_fetch_if bus ();

    riscv_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        glog.delete();
        ppc.delete();
        pinst.delete();
        rst_n = 1'b1;
    endtask

    // memory model: inputs change at negedge+1, after the main process
    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                mq.delete();
                bus.imem_gnt_i    = 1'b0;
                bus.imem_rvalid_i = 1'b0;
                bus.imem_rdata_i  = '0;
            end else begin
                if (mq.size() != 0 && !hold_resp) begin
                    bus.imem_rvalid_i = 1'b1;
                    bus.imem_rdata_i  = mq.pop_front();
                end else begin
                    bus.imem_rvalid_i = 1'b0;
                    bus.imem_rdata_i  = '0;
                end
                bus.imem_gnt_i = gnt_en;
                if (bus.imem_req_o && gnt_en) mq.push_back(bus.imem_addr_o);
            end
        end
    end

    // monitor: logs grants and decode handshakes that the next posedge will complete
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (bus.imem_req_o && bus.imem_gnt_i) glog.push_back(bus.imem_addr_o);
            if (bus.inst_valid_o && bus.inst_ready_i) begin
                ppc.push_back(bus.inst_pc_o);
                pinst.push_back(bus.inst_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        rst_n = 1'b1;
        gnt_en = 1'b1;
        hold_resp = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = '0;
        bus.inst_ready_i = 1'b1;
        #1 rst_n = 1'b0;

        // reset values
        tick(1); #2;
        chk("rst_req", 32'(bus.imem_req_o), 32'd0);
        chk("rst_addr", bus.imem_addr_o, 32'h0);
        chk("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("rst_inst", bus.inst_o, 32'h0);
        chk("rst_pc", bus.inst_pc_o, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #2;
        chk("boot_noreq", 32'(bus.imem_req_o), 32'd0);
        @(negedge clk); #2;
        chk("first_req", 32'(bus.imem_req_o), 32'd1);
        chk("first_addr", bus.imem_addr_o, 32'h0);

        // 1: streaming, sequential PCs with data=addr
        tick(30);
        for (int i = 0; i < 8; i++) begin
            chk("t1_addr", qat(glog, i), 32'(4 * i));
            chk("t1_pc", qat(ppc, i), 32'(4 * i));
            chk("t1_inst", qat(pinst, i), 32'(4 * i));
        end

        // 2: decode stalled, credit limits to FIFO_DEPTH words
        bus.inst_ready_i = 1'b0;
        do_reset();
        tick(12);
        chk("t2_grants", 32'(glog.size()), 32'd2);
        chk("t2_req_off", 32'(bus.imem_req_o), 32'd0);
        chk("t2_valid", 32'(bus.inst_valid_o), 32'd1);
        chk("t2_head", bus.inst_pc_o, 32'h0);
        bus.inst_ready_i = 1'b1;
        tick(20);
        for (int i = 0; i < 6; i++) chk("t2_pc", qat(ppc, i), 32'(4 * i));

        // 3: redirect with two requests outstanding
        hold_resp = 1'b1;
        do_reset();
        tick(5);
        chk("t3_two_out", 32'(glog.size()), 32'd2);
        chk("t3_req_sat", 32'(bus.imem_req_o), 32'd0);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h0000_0103;
        hold_resp = 1'b0;
        tick(1);
        bus.redirect_i = 1'b0;
        tick(10);
        chk("t3_new_addr", qat(glog, 2), 32'h100);
        chk("t3_pc0", qat(ppc, 0), 32'h100);
        chk("t3_inst0", qat(pinst, 0), 32'h100);
        chk("t3_pc1", qat(ppc, 1), 32'h104);

        // 4: redirect while a request waits for gnt
        do_reset();
        found = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (glog.size() >= 2) begin found = 1; break; end
        end
        chk("t4_two_grants", 32'(found), 32'd1);
        gnt_en = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (bus.imem_req_o && bus.imem_addr_o == 32'h8) begin found = 1; break; end
        end
        chk("t4_req8", 32'(found), 32'd1);
        tick(1);
        chk("t4_hold_a", bus.imem_addr_o, 32'h8);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h200;
        tick(1);
        bus.redirect_i = 1'b0;
        chk("t4_hold_b", bus.imem_addr_o, 32'h8);
        chk("t4_req_b", 32'(bus.imem_req_o), 32'd1);
        tick(1);
        chk("t4_hold_c", bus.imem_addr_o, 32'h8);
        gnt_en = 1'b1;
        tick(12);
        chk("t4_g2", qat(glog, 2), 32'h8);
        chk("t4_g3", qat(glog, 3), 32'h200);
        chk("t4_pc0", qat(ppc, 0), 32'h0);
        chk("t4_pc1", qat(ppc, 1), 32'h4);
        chk("t4_pc2", qat(ppc, 2), 32'h200);
        chk("t4_inst2", qat(pinst, 2), 32'h200);

        // 5: redirect coinciding with rvalid and a decode handshake
        do_reset();
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #3;
            if (bus.inst_valid_o && bus.imem_rvalid_i) begin found = 1; break; end
        end
        chk("t5_coincide", 32'(found), 32'd1);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h40;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        chk("t5_flushed", 32'(bus.inst_valid_o), 32'd0);
        tick(10);
        chk("t5_pc0", qat(ppc, 0), 32'h0);
        chk("t5_pc1", qat(ppc, 1), 32'h40);
        chk("t5_inst1", qat(pinst, 1), 32'h40);

        // 6: reset asserted mid-stream
        do_reset();
        found = 0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            if (bus.imem_req_o && bus.inst_valid_o) begin found = 1; break; end
        end
        chk("t6_busy", 32'(found), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("t6_req", 32'(bus.imem_req_o), 32'd0);
        chk("t6_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("t6_addr", bus.imem_addr_o, 32'h0);
        tick(2);
        rst_n = 1'b1;
        @(negedge clk); #2;
        chk("t6_boot", 32'(bus.imem_req_o), 32'd0);
        @(negedge clk); #2;
        chk("t6_req1", 32'(bus.imem_req_o), 32'd1);
        chk("t6_addr1", bus.imem_addr_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
